// File: rtl/readpixel_cmd_decoder_pkg.sv
// Shared types and sizing for the read-pixel command payload decoder.
// Field widths are fixed here so the framebuffer address struct has a single definition.
package readpixel_cmd_decoder_pkg;

  function automatic int unsigned num_bytes_to_contain(int unsigned bits);
    return (bits + 7) / 8;
  endfunction

  localparam int unsigned ROW_BITS        = 5;
  localparam int unsigned COL_BITS        = 6;
  localparam int unsigned BYTES_PER_PIXEL = 2;

  localparam int unsigned ROW_BYTES = num_bytes_to_contain(ROW_BITS);
  localparam int unsigned COL_BYTES = num_bytes_to_contain(COL_BITS);
  localparam int unsigned PIX_BITS  = (BYTES_PER_PIXEL > 2) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS + PIX_BITS;

  // The byte counter is shared by all three fields, so size it for the longest one.
  localparam int unsigned MAX_BYTES =
      (ROW_BYTES > COL_BYTES) ?
        ((ROW_BYTES > BYTES_PER_PIXEL) ? ROW_BYTES : BYTES_PER_PIXEL) :
        ((COL_BYTES > BYTES_PER_PIXEL) ? COL_BYTES : BYTES_PER_PIXEL);
  localparam int unsigned CNT_BITS  = (MAX_BYTES > 2) ? $clog2(MAX_BYTES) : 1;

  typedef logic [ROW_BITS-1:0] row_addr_t;
  typedef logic [COL_BITS-1:0] col_addr_t;
  typedef logic [PIX_BITS-1:0] pixel_addr_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  typedef struct packed {
    row_addr_t   row;
    col_addr_t   col;
    pixel_addr_t pixel;
  } fb_addr_t;

  typedef enum logic [1:0] {
    StRow,
    StCol,
    StData
  } state_t;

endpackage

// File: rtl/readpixel_cmd_decoder.sv
// Turns the row/column/colour payload of a read-pixel command into framebuffer write strobes.
// All outputs are registered; each accepted byte takes effect on the edge that samples it.
module readpixel_cmd_decoder
  import readpixel_cmd_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           data_in,
  output logic [ADDR_BITS-1:0] addr,
  output logic [7:0]           data_out,
  output logic                 ram_write_enable,
  output logic                 ram_access_start,
  output logic                 done
);

  localparam cnt_t ROW_LAST = cnt_t'(ROW_BYTES - 1);
  localparam cnt_t COL_LAST = cnt_t'(COL_BYTES - 1);
  localparam cnt_t PIX_LAST = cnt_t'(BYTES_PER_PIXEL - 1);

  state_t      state_q;
  cnt_t        cnt_q;
  fb_addr_t    addr_q;
  logic [7:0]  data_q;
  logic        we_q;
  logic        start_q;
  logic        done_q;
  pixel_addr_t pix_slot;

  // First colour byte lands in the highest pixel-byte slot.
  always_comb begin
    pix_slot = pixel_addr_t'(BYTES_PER_PIXEL - 1) - pixel_addr_t'(cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRow;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          StRow: begin
            addr_q.row <= row_addr_t'({addr_q.row, data_in});
            data_q     <= '0;
            if (cnt_q == ROW_LAST) begin
              cnt_q   <= '0;
              state_q <= StCol;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StCol: begin
            addr_q.col <= col_addr_t'({addr_q.col, data_in});
            if (cnt_q == COL_LAST) begin
              cnt_q   <= '0;
              state_q <= StData;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StData: begin
            data_q       <= data_in;
            addr_q.pixel <= pix_slot;
            we_q         <= 1'b1;
            start_q      <= ~start_q;
            if (cnt_q == PIX_LAST) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= StRow;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= StRow;
          end
        endcase
      end
    end
  end

  assign addr             = addr_q;
  assign data_out         = data_q;
  assign ram_write_enable = we_q;
  assign ram_access_start = start_q;
  assign done             = done_q;

endmodule

// File: tb/tb_readpixel_cmd_decoder.sv
// Scoreboard bench for readpixel_cmd_decoder (ROW_BITS=5, COL_BITS=6, BYTES_PER_PIXEL=2).
// Expected writes are queued as colour bytes are driven and popped on each write strobe.
module tb_readpixel_cmd_decoder;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        as;
    logic        done;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  data_in;
  logic [11:0] addr;
  logic [7:0]  data_out;
  logic        ram_write_enable;
  logic        ram_access_start;
  logic        done;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_we;
  int unsigned n_done;
  int unsigned n_tog;
  logic        prev_as;

  wr_t         sb[$];

  // Reference model of the stream position and last decoded fields.
  int unsigned m_idx;
  logic [4:0]  m_row;
  logic [5:0]  m_col;
  logic        m_as;

  readpixel_cmd_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .data_in          (data_in),
    .addr             (addr),
    .data_out         (data_out),
    .ram_write_enable (ram_write_enable),
    .ram_access_start (ram_access_start),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_row = '0;
    m_col = '0;
    m_as  = 1'b0;
  endtask

  // Called at a negedge; returns at the next negedge with the byte's effect visible.
  task automatic drive(input logic [7:0] b);
    wr_t e;
    enable  = 1'b1;
    data_in = b;
    case (m_idx)
      0: m_row = b[4:0];
      1: m_col = b[5:0];
      default: begin
        m_as   = ~m_as;
        e.addr = {m_row, m_col, (m_idx == 2) ? 1'b1 : 1'b0};
        e.data = b;
        e.as   = m_as;
        e.done = (m_idx == 3);
        sb.push_back(e);
      end
    endcase
    @(negedge clk);
    case (m_idx)
      0: begin
        check("row", 32'(addr[11:7]), 32'(m_row));
        check("row_we", 32'(ram_write_enable), 0);
        check("row_dout", 32'(data_out), 0);
      end
      1: begin
        check("col", 32'(addr[6:1]), 32'(m_col));
        check("col_we", 32'(ram_write_enable), 0);
      end
      default: ;
    endcase
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic idle(input int n, input bit stable_chk);
    logic [20:0] snap;
    enable = 1'b0;
    @(negedge clk);
    snap = {addr, data_out, ram_access_start};
    repeat (n - 1) @(negedge clk);
    if (stable_chk) begin
      check("gap_hold", 32'({addr, data_out, ram_access_start}), 32'(snap));
      check("gap_we", 32'(ram_write_enable), 0);
      check("gap_done", 32'(done), 0);
    end
  endtask

  task automatic send_cmd(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d0,
                          input logic [7:0] d1, input int gap);
    drive(r);
    if (gap > 0) idle(gap, 1'b1);
    drive(c);
    if (gap > 0) idle(gap, 1'b1);
    drive(d0);
    if (gap > 0) idle(gap, 1'b1);
    drive(d1);
    if (gap > 0) idle(gap, 1'b1);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      prev_as = ram_access_start;
    end else begin
      if (ram_access_start !== prev_as) n_tog++;
      prev_as = ram_access_start;
      if (done) n_done++;
      if (ram_write_enable) begin
        n_we++;
        if (sb.size() == 0) begin
          check("spurious_we", 32'(ram_write_enable), 0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(addr), 32'(e.addr));
          check("wr_data", 32'(data_out), 32'(e.data));
          check("wr_as", 32'(ram_access_start), 32'(e.as));
          check("wr_done", 32'(done), 32'(e.done));
        end
      end else if (done) begin
        check("done_without_we", 32'(done), 0);
      end
    end
  end

  initial begin
    int unsigned we0, done0, tog0;
    n_vec   = 0;
    n_err   = 0;
    n_we    = 0;
    n_done  = 0;
    n_tog   = 0;
    prev_as = 1'b0;
    reset   = 1'b0;
    enable  = 1'b0;
    data_in = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_we", 32'(ram_write_enable), 0);
    check("rst_as", 32'(ram_access_start), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_out", 32'({addr, data_out, ram_write_enable, ram_access_start, done}), 0);

    // Single command from the reference stream.
    we0 = n_we; done0 = n_done;
    send_cmd(8'h0A, 8'h05, 8'hF8, 8'h1F, 0);
    idle(2, 1'b0);
    check("single_we_cnt", n_we - we0, 2);
    check("single_done_cnt", n_done - done0, 1);

    // Two commands back to back.
    we0 = n_we; done0 = n_done; tog0 = n_tog;
    send_cmd(8'h03, 8'h21, 8'h12, 8'h34, 0);
    send_cmd(8'h1C, 8'h3E, 8'hAB, 8'hCD, 0);
    idle(2, 1'b0);
    check("b2b_we_cnt", n_we - we0, 4);
    check("b2b_done_cnt", n_done - done0, 2);
    check("b2b_toggles", n_tog - tog0, 4);

    // Long idle gaps between bytes.
    we0 = n_we; done0 = n_done;
    send_cmd(8'h11, 8'h2A, 8'h5A, 8'hA5, 16);
    check("gap_we_cnt", n_we - we0, 2);
    check("gap_done_cnt", n_done - done0, 1);

    // Field truncation at the maximum byte values.
    send_cmd(8'hFF, 8'h7F, 8'h00, 8'hFF, 0);
    idle(2, 1'b0);
    check("trunc_row", 32'(addr[11:7]), 31);
    check("trunc_col", 32'(addr[6:1]), 63);

    // Abort mid-command after the column byte.
    drive(8'h07);
    drive(8'h09);
    enable = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rst_out", 32'({addr, data_out, ram_write_enable, ram_access_start, done}), 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    we0 = n_we; done0 = n_done;
    send_cmd(8'h15, 8'h30, 8'hC3, 8'h3C, 1);
    idle(2, 1'b0);
    check("abort_we_cnt", n_we - we0, 2);
    check("abort_done_cnt", n_done - done0, 1);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/readpixel_cmd_decoder.md
Name: readpixel_cmd_decoder

Overview:
Command-payload decoder for the "read pixel" control command, placed after the opcode dispatcher in the control path. It consumes the byte stream that follows the opcode (row address, column address, then pixel colour bytes) and turns it into framebuffer RAM write transactions. For each colour byte it issues one write strobe with the framebuffer address and data, then pulses done.

Parameters:
ROW_BITS, 5, width of the row address; ROW_BYTES = ceil(ROW_BITS/8).
COL_BITS, 6, width of the column address; COL_BYTES = ceil(COL_BITS/8).
BYTES_PER_PIXEL, 2, colour bytes per pixel; PIX_BITS = max(1, clog2(BYTES_PER_PIXEL)).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
enable  in  1  byte strobe; each high cycle means data_in holds one valid stream byte.
data_in  in  8  payload byte.
addr  out  ROW_BITS+COL_BITS+PIX_BITS  framebuffer address struct {row, col, pixel}.
data_out  out  8  byte to write into the framebuffer.
ram_write_enable  out  1  write strobe.
ram_access_start  out  1  toggles once per RAM write (toggle handshake for the RAM arbiter).
done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, state=ROW, byte counter=0.
- All outputs are registered. Effects of a byte appear on the clk edge that samples enable=1, so they are visible in the next cycle.
- Stream order is row bytes, then column bytes, then colour bytes, each field MSB byte first. Total length is ROW_BYTES+COL_BYTES+BYTES_PER_PIXEL.
- State ROW: shift data_in into addr.row. Upper bits beyond ROW_BITS are discarded, so with one byte addr.row = data_in[ROW_BITS-1:0]. Force ram_write_enable=0 and data_out=0. After ROW_BYTES bytes, go to COL.
- State COL: shift data_in into addr.col the same way, with ram_write_enable=0. After COL_BYTES bytes, go to DATA with counter k=0.
- State DATA, byte k (k=0..BYTES_PER_PIXEL-1), in the cycle after enable:
  - data_out=data_in
  - addr.pixel = BYTES_PER_PIXEL-1-k (the first colour byte goes to the highest pixel-byte slot)
  - ram_write_enable=1
  - ram_access_start inverted
- ram_write_enable is a one-cycle pulse per colour byte and is 0 in every other cycle.
- On the last colour byte (k=BYTES_PER_PIXEL-1), done=1 in the same cycle as that byte's write strobe. Then state returns to ROW and counters clear.
- done is high for exactly one cycle per command.
- A new stream may begin on the very next enable after done. addr and ram_access_start hold their values between commands.
- enable held high for several cycles counts as one byte per cycle. Bytes arrive no faster than one per cycle, with arbitrary idle gaps.
- Cycles with enable=0 change nothing except clearing the ram_write_enable and done pulses.
- Reset mid-stream aborts the command: the partial command is discarded and the next byte is treated as a row byte.

Decomposition:
- Shared package (types/params) holds:
  - row_addr_t, col_addr_t, pixel_addr_t
  - fb_addr_t packed struct {row, col, pixel}
  - BYTES_PER_PIXEL
  - a calc helper num_bytes_to_contain(bits)
- Single module containing a 3-state FSM (ROW, COL, DATA) and one byte counter. No sub-module is needed.
- The byte-strobe source (slow-clock divider plus edge synchroniser) lives outside this block.

Test Plan:
- Reset: hold reset=0 → all outputs 0, done=0, state ROW; release reset → outputs still 0 until the first enable.
- Single command, stream bytes 0x0A, 0x05, 0xF8, 0x1F:
  - after byte 0: addr.row=10, we=0, data_out=0
  - after byte 1: addr.col=5, we=0
  - after byte 2: we=1, data_out=0xF8, pixel=1, as toggled
  - after byte 3: we=1, data_out=0x1F, pixel=0, as toggled, done=1 in the same cycle
- Back-to-back: two commands with no gap → each produces exactly 2 write strobes and 1 done; ram_access_start toggles 4 times total.
- Idle gaps of 16 clocks between bytes → we and done are single-cycle pulses; no outputs change during gaps.
- Row value 0xFF with ROW_BITS=5 → addr.row=31 (truncation); column 0x7F with COL_BITS=6 → addr.col=63.
- Reset asserted after the column byte, then a full command → the stale partial command is discarded and the new command decodes correctly with done after exactly BYTES_PER_PIXEL writes.
